// File: rtl/pow_pkg.sv
// Shared types and constants for the power-engine job dispatcher.
package pow_pkg;

    localparam int DATA_W    = 32;
    localparam int JOB_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    // Canonical job layout; the FIFO stores jobs packed in this field order.
    typedef struct packed {
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [JOB_TAG_W-1:0] tag;
    } job_t;

endpackage

// File: rtl/pow_job_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued power jobs.
module pow_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 68
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // full is taken from the pre-pop count, so a push in a pop cycle on a full FIFO is refused
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pow_dispatch.sv
// Job front-end for the square-and-multiply engine: queues jobs, issues one at a
// time, and returns (result, tag) on a valid/ready port in job order.
module pow_dispatch #(
    parameter int DATA_W = pow_pkg::DATA_W,
    parameter int TAG_W  = pow_pkg::JOB_TAG_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              eng_start,
    output logic [DATA_W-1:0] eng_a,
    output logic [DATA_W-1:0] eng_b,
    input  logic [DATA_W-1:0] eng_result,
    input  logic              eng_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy,
    output logic [15:0]       jobs_done
);

    import pow_pkg::*;

    localparam int JW = 2*DATA_W + TAG_W;

    state_t           state;
    state_t           state_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             capture;
    logic [JW-1:0]    head;
    logic [TAG_W-1:0] tag_q;

    pow_job_fifo #(.DEPTH(DEPTH), .WIDTH(JW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop),
        .wdata ({in_a, in_b, in_tag}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign eng_start = (state == ISSUE);
    assign busy      = !fifo_empty || (state != IDLE) || out_valid;

    // Holding off issue while out_valid is high keeps one job in flight and
    // guarantees a pending result is never overwritten.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !out_valid) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:     state_nxt = WAIT_LOW;
            // done is still high from the previous job until the engine starts
            WAIT_LOW:  if (!eng_done) state_nxt = WAIT_HIGH;
            WAIT_HIGH: begin
                if (eng_done) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            eng_a      <= '0;
            eng_b      <= '0;
            tag_q      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            jobs_done  <= '0;
        end else begin
            if (pop) {eng_a, eng_b, tag_q} <= head;
            if (capture) begin
                out_valid  <= 1'b1;
                out_result <= eng_result;
                out_tag    <= tag_q;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) jobs_done <= jobs_done + 16'd1;
        end
    end

endmodule
